neuron_accum_ctrl: RTL and testbench
====================================

// Module: neuron_accum_ctrl
// PURPOSE
//  Sequences one neuron's dot-product accumulation through a single shared 16-bit saturating adder.
//  Loads a bias, then accepts LEN signed Q-format partial products over a valid/ready stream.
//  Folds each term into the accumulator with saturation.
//  Presents the result, with optional ReLU, on a valid/ready output to the next NPU layer stage.
// PARAMETERS
//  LEN_WIDTH  10  width of term count; max job length 2**LEN_WIDTH-1 (784 MNIST pixels fits)
//  RELU_EN    1   1: clamp negative final result to 0x0000 at output; 0: pass signed result
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  start      in   1   job request; sampled only in IDLE
//  len        in   LEN_WIDTH  number of terms in the job; captured on accepted start
//  bias       in   16  signed initial accumulator value; captured on accepted start
//  in_data    in   16  signed partial product
//  in_valid   in   1   in_data valid
//  in_ready   out  1   term accepted when in_valid & in_ready
//  out_data   out  16  final result (post-ReLU when RELU_EN=1)
//  out_valid  out  1   result valid; held until accepted
//  out_ready  in   1   result accepted when out_valid & out_ready
//  busy       out  1   high in ACC or DONE
//  sat_flag   out  1   sticky per job: any add in this job saturated; cleared on accepted start
// BEHAVIOUR
//  Reset: state=IDLE; acc, cnt, len_q and out_data = 0; in_ready, out_valid, busy and sat_flag = 0.
//  Saturating add, the only arithmetic path (one adder instance, shared by all terms):
//   - s = sext17(acc) + sext17(in_data).
//   - s[16:15]=01 -> 0x7FFF; s[16:15]=10 -> 0x8000; otherwise s[15:0].
//   - Saturation is applied after every term. Order is therefore significant and is arrival order.
//  FSM IDLE:
//   - in_ready=0, out_valid=0.
//   - start=1 and len!=0: acc<=bias, len_q<=len, cnt<=0, sat_flag<=0, go to ACC.
//   - start=1 and len==0: acc<=bias, sat_flag<=0, go to DONE.
//  FSM ACC:
//   - in_ready=1.
//   - Each handshake: acc<=satadd(acc,in_data), cnt<=cnt+1, sat_flag|=overflow.
//   - Handshake with cnt==len_q-1: go to DONE.
//   - No handshake: hold all state. in_valid bubbles are allowed.
//  FSM DONE:
//   - out_valid=1, in_ready=0.
//   - out_data = (RELU_EN && acc[15]) ? 0 : acc.
//   - out_data and sat_flag are stable while out_valid & !out_ready.
//   - On out_ready: go to IDLE, out_valid=0 next cycle.
//  Timing:
//   - out_valid rises the cycle after the last term handshake, or the cycle after start when len==0.
//   - Throughput: 1 term per cycle.
//   - Min job time: len + 2 cycles plus output wait.
//  start while busy: ignored, never queued. A start in the same cycle as the DONE->IDLE transition is also ignored.
//  Reset mid-job: job discarded, back to IDLE, no out_valid produced.
//  sat_flag reflects the last job until the next accepted start.
//  cnt never wraps: len_q <= 2**LEN_WIDTH-1.
// TESTING
//  T1 bias=10, len=3, terms 1,2,3 -> out_data=16, sat_flag=0, out_valid 1 cycle after 3rd handshake.
//  T2 bias=0x7000, len=2, terms 0x2000,0xF000 -> 0x7FFF then 0x6FFF; out_data=0x6FFF, sat_flag=1.
//  T3 RELU_EN=0: bias=0, len=1, term 0xFFFB -> out_data=0xFFFB; RELU_EN=1 -> out_data=0x0000.
//  T4 len=0, bias=0x0123 -> out_valid next cycle with out_data=0x0123, in_ready never asserted.
//  T5 out_ready low 5 cycles and start pulsed during DONE -> out_data stable; start ignored; IDLE after accept.
//  T6 rst high after 2 of 4 terms, then a new job bias=1, len=1, term 1 -> out_data=2, no stale output.

Source files
------------

// File: rtl/neuron_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : neuron_accum_ctrl
// Brief    : Bias + streamed-term dot-product accumulator with a single shared
//            16-bit saturating adder and optional ReLU on the result.
// Revision : 1.0  initial release
// ============================================================================
module neuron_accum_ctrl #(
    parameter int LEN_WIDTH = 10,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [15:0]          bias,
    input  logic [15:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [15:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 sat_flag
);

    localparam logic [LEN_WIDTH-1:0] C_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] C_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [15:0]            out_data_q, out_data_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   sat_q, sat_d;

    logic [16:0]            w_sum;
    logic [15:0]            w_sat_sum;
    logic                   w_ovf;
    logic                   w_hs;
    logic                   w_last;

    function automatic logic [15:0] relu(input logic [15:0] v);
        return (RELU_EN && v[15]) ? 16'h0000 : v;
    endfunction

    // The one adder: the two top bits of the 17-bit sum disagree only on overflow.
    assign w_sum     = {acc_q[15], acc_q} + {in_data[15], in_data};
    assign w_ovf     = w_sum[16] ^ w_sum[15];
    assign w_sat_sum = (w_sum[16:15] == 2'b01) ? 16'h7FFF :
                       (w_sum[16:15] == 2'b10) ? 16'h8000 : w_sum[15:0];
    assign w_hs      = in_valid & in_ready_q;
    assign w_last    = (cnt_q == (len_q - C_ONE));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        sat_d       = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d  = bias;
                    sat_d  = 1'b0;
                    busy_d = 1'b1;
                    if (len != C_ZERO) begin
                        len_d      = len;
                        cnt_d      = C_ZERO;
                        in_ready_d = 1'b1;
                        state_d    = ST_ACC;
                    end else begin
                        out_data_d  = relu(bias);
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_ACC: begin
                if (w_hs) begin
                    acc_d = w_sat_sum;
                    cnt_d = cnt_q + C_ONE;
                    sat_d = sat_q | w_ovf;
                    if (w_last) begin
                        in_ready_d  = 1'b0;
                        out_data_d  = relu(w_sat_sum);
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // start is not looked at here, so a start on the accept cycle is dropped.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= 16'h0000;
            cnt_q       <= C_ZERO;
            len_q       <= C_ZERO;
            out_data_q  <= 16'h0000;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_accum_ctrl
// Brief    : Randomized bench for neuron_accum_ctrl (ReLU and linear builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_neuron_accum_ctrl;

    localparam int LEN_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic [15:0]      bias_i = '0;
    logic [15:0]      in_data = '0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;

    logic        ir_r, ov_r, busy_r, sat_r;
    logic [15:0] od_r;
    logic        ir_l, ov_l, busy_l, sat_l;
    logic [15:0] od_l;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] terms[$];

    always #5 clk = ~clk;

    neuron_accum_ctrl #(.LEN_WIDTH(LEN_W), .RELU_EN(1'b1)) u_dut_relu (
        .clk(clk), .rst(rst), .start(start), .len(len_i), .bias(bias_i),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir_r),
        .out_data(od_r), .out_valid(ov_r), .out_ready(out_ready),
        .busy(busy_r), .sat_flag(sat_r)
    );

    neuron_accum_ctrl #(.LEN_WIDTH(LEN_W), .RELU_EN(1'b0)) u_dut_lin (
        .clk(clk), .rst(rst), .start(start), .len(len_i), .bias(bias_i),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir_l),
        .out_data(od_l), .out_valid(ov_l), .out_ready(out_ready),
        .busy(busy_l), .sat_flag(sat_l)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input bit e_ir, input bit e_ov, input bit e_busy);
        check({tag, " in_ready(relu)"},  ir_r,   e_ir);
        check({tag, " out_valid(relu)"}, ov_r,   e_ov);
        check({tag, " busy(relu)"},      busy_r, e_busy);
        check({tag, " in_ready(lin)"},   ir_l,   e_ir);
        check({tag, " out_valid(lin)"},  ov_l,   e_ov);
        check({tag, " busy(lin)"},       busy_l, e_busy);
    endtask

    task automatic check_res(input string tag, input logic [15:0] e_lin, input bit e_sat);
        logic [15:0] e_relu;
        e_relu = e_lin[15] ? 16'h0000 : e_lin;
        check({tag, " out_data(relu)"}, od_r,  e_relu);
        check({tag, " out_data(lin)"},  od_l,  e_lin);
        check({tag, " sat_flag(relu)"}, sat_r, e_sat);
        check({tag, " sat_flag(lin)"},  sat_l, e_sat);
    endtask

    // Reference: integer running sum clamped to the int16 range after each term.
    task automatic model(input logic [15:0] b, input int n, output logic [15:0] res, output bit sat);
        int acc;
        acc = int'($signed(b));
        sat = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = acc + int'($signed(terms[i]));
            if (acc > 32767)  begin acc = 32767;  sat = 1'b1; end
            if (acc < -32768) begin acc = -32768; sat = 1'b1; end
        end
        res = acc[15:0];
    endtask

    task automatic run_job(input string tag, input logic [15:0] b, input int n,
                           input int bubble_pct, input int wait_cyc, input bit poke_start);
        logic [15:0] e_res;
        bit          e_sat;
        int          i;
        model(b, n, e_res, e_sat);
        start  = 1'b1;
        len_i  = n[LEN_W-1:0];
        bias_i = b;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        while (i < n) begin
            check_ctl({tag, " acc"}, 1'b1, 1'b0, 1'b1);
            in_valid = ($urandom_range(99) >= bubble_pct);
            in_data  = in_valid ? terms[i] : 16'($urandom);
            @(posedge clk); #1;
            if (in_valid) i++;
            in_valid = 1'b0;
        end
        check_ctl({tag, " done"}, 1'b0, 1'b1, 1'b1);
        check_res({tag, " done"}, e_res, e_sat);
        for (int w = 0; w < wait_cyc; w++) begin
            if (poke_start) begin
                start  = 1'b1;
                len_i  = 10'd1;
                bias_i = 16'($urandom);
            end
            @(posedge clk); #1;
            check_ctl({tag, " hold"}, 1'b0, 1'b1, 1'b1);
            check_res({tag, " hold"}, e_res, e_sat);
        end
        start     = poke_start;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        check_ctl({tag, " idle"}, 1'b0, 1'b0, 1'b0);
        check({tag, " sat kept"}, sat_l, e_sat);
    endtask

    initial begin
        logic [15:0] b;
        int          n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check_res("reset", 16'h0000, 1'b0);

        terms = '{16'd1, 16'd2, 16'd3};
        run_job("T1", 16'd10, 3, 0, 0, 1'b0);
        terms = '{16'h2000, 16'hF000};
        run_job("T2", 16'h7000, 2, 30, 1, 1'b0);
        terms = '{16'hFFFB};
        run_job("T3", 16'h0000, 1, 0, 0, 1'b0);
        terms = {};
        run_job("T4", 16'h0123, 0, 0, 2, 1'b0);
        terms = '{16'h8000, 16'hFFFF, 16'd5};
        run_job("T5", 16'h0000, 3, 20, 5, 1'b1);

        // Reset two terms into a four-term job; nothing may come out of it.
        start = 1'b1; len_i = 10'd4; bias_i = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 16'h7000;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_ctl("T6 after rst", 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        check_res("T6 after rst", 16'h0000, 1'b0);
        terms = '{16'd1};
        run_job("T6 new", 16'd1, 1, 0, 0, 1'b0);

        // Longest job the counter allows.
        terms = {};
        for (int k = 0; k < 1023; k++) terms.push_back(16'($signed($urandom_range(8)) - 4));
        run_job("maxlen", 16'($urandom), 1023, 0, 1, 1'b0);

        for (int j = 0; j < 40; j++) begin
            n = $urandom_range(12);
            terms = {};
            for (int k = 0; k < n; k++)
                terms.push_back(($urandom_range(1) == 1) ? 16'($urandom) : 16'($signed($urandom_range(512)) - 256));
            b = 16'($urandom);
            run_job("rand", b, n, $urandom_range(50), $urandom_range(3), 1'($urandom_range(1)));
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
